btn_repeat_conditioner: RTL and testbench
=========================================

# btn_repeat_conditioner

Single-channel push-button conditioner for the 7-segment animation/speed controls. It synchronises one raw switch input, debounces both press and release, and emits one-cycle command pulses with optional hold-to-repeat, so a held speed or animation button steps continuously. It sits directly upstream of the segment/animation controller: one instance per `ui_in[3:0]` button, with `pulse_o` feeding the controller's increment/decrement inputs.

## Interface
- `SYNC_STAGES`, 2: synchroniser flop count; must be >= 2.
- `DEBOUNCE_CYCLES`, 100_000: stable cycles required to accept a press or release (10 ms at 10 MHz); must be >= 1.
- `REPEAT_DELAY`, 5_000_000: held cycles from the accepted press to the first repeat pulse (500 ms); must be >= 1.
- `REPEAT_PERIOD`, 1_000_000: cycles between subsequent repeat pulses (100 ms); must be >= 1.
- `clk` in 1: single clock for all state, 10 MHz nominal.
- `rst_n` in 1: asynchronous, active-low reset.
- `button_in` in 1: raw, asynchronous, bouncing button level; active high.
- `enable` in 1: synchronous enable; 0 forces the FSM to IDLE.
- `repeat_en` in 1: 1 permits hold-to-repeat; sampled every cycle.
- `pulse_o` out 1: one-cycle command pulse for the accepted press and for each repeat.
- `repeat_o` out 1: qualifies `pulse_o`; 1 when the pulse is a repeat, not the initial press.
- `level_o` out 1: debounced button level.
- `release_o` out 1: one-cycle pulse when a release is accepted.

## Operation
- Synchroniser: a `SYNC_STAGES` shift register clears to 0 on reset. Its last stage is `btn_s`. Nothing downstream sees `button_in` directly.
- The block uses one shared down-counter (or up-counter). Its width is `$clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1)`. It clears on every state change, and comparisons are against `N-1`.
- FSM states: IDLE, PRESS_DB, HOLD_DELAY, HOLD_REPEAT, RELEASE_DB.
  - IDLE: `btn_s`=1 moves to PRESS_DB.
  - PRESS_DB: `btn_s`=0 returns to IDLE with no output (glitch rejected). Counter reaching `DEBOUNCE_CYCLES-1` with `btn_s`=1 moves to HOLD_DELAY and sets `pulse_o`=1, `repeat_o`=0.
  - HOLD_DELAY: `btn_s`=0 moves to RELEASE_DB. With `repeat_en`=1 and the counter at `REPEAT_DELAY-1`, move to HOLD_REPEAT and set `pulse_o`=1, `repeat_o`=1. With `repeat_en`=0 the counter saturates and the state holds.
  - HOLD_REPEAT: `btn_s`=0 moves to RELEASE_DB. Counter at `REPEAT_PERIOD-1` sets `pulse_o`=1, `repeat_o`=1 and clears the counter. `repeat_en` falling to 0 returns to HOLD_DELAY (counter cleared) with no pulse.
  - RELEASE_DB: `btn_s`=1 (release bounce) returns to HOLD_DELAY with the counter cleared and no pulse. Counter at `DEBOUNCE_CYCLES-1` with `btn_s`=0 moves to IDLE and sets `release_o`=1.
- `level_o` is 1 in HOLD_DELAY, HOLD_REPEAT and RELEASE_DB, and 0 otherwise. It is registered alongside the state.
- `enable`=0 has priority over all transitions. The next edge forces IDLE, counter 0, and all outputs 0. The synchroniser keeps running. A button already held when `enable` rises must pass full PRESS_DB before any pulse.
- All outputs are registered, with no combinational path from inputs.

## Timing
- Reset (async assert): state IDLE, counter 0, synchroniser 0. `pulse_o`, `repeat_o`, `level_o` and `release_o` are all 0. Deassertion is taken synchronously by the design's reset synchroniser.
- Press latency, counting edge 1 as the first edge sampling `button_in`=1 and holding it stable: `pulse_o` and `level_o` go high after edge `SYNC_STAGES+DEBOUNCE_CYCLES+1`. `pulse_o` stays high for exactly one cycle.
- The first repeat pulse comes `REPEAT_DELAY` edges after the press pulse. Later repeats come every `REPEAT_PERIOD` edges.
- Release latency follows the same formula: `release_o` and `level_o`=0 at edge `SYNC_STAGES+DEBOUNCE_CYCLES+1` after the first low sample.
- `pulse_o` and `release_o` are never high together. No two `pulse_o` assertions are closer than `min(REPEAT_DELAY, REPEAT_PERIOD)` cycles.
- Reset mid-operation aborts immediately and emits no release pulse.

## Test plan
Parameters: `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.
- Reset applied, `button_in` toggling -> all four outputs stay 0 throughout reset.
- `button_in` high at edge 1 and held 20 cycles, `repeat_en`=0 -> `pulse_o` high only after edge 7 with `repeat_o`=0. `level_o` high from edge 7. Low at edge 21 -> `release_o` one cycle after edge 27, `level_o`=0.
- `button_in` high for 3 cycles, then 1-cycle bursts every 2 cycles -> `pulse_o`, `level_o` and `release_o` never assert.
- Hold 40 cycles, `repeat_en`=1 -> pulses after edges 7, 17, 20, 23, 26, ..., 38. `repeat_o`=0 only at edge 7.
- While held: low 2 cycles, high 2, then stable low -> single `release_o` only after the final stable-low debounce; no extra `pulse_o`; `level_o` stays 1 until then.
- `rst_n`=0 at edge 15 of a repeating hold, and separately `enable`=0 -> outputs 0 immediately / after the next edge. After re-enable with the button still held, the next `pulse_o` comes 5 edges later (PRESS_DB entry plus 4 debounce cycles).

Source files
------------

// File: rtl/btn_repeat_conditioner.sv
// Push-button conditioner: synchronises a raw button, debounces press and release,
// and emits one-cycle command pulses with optional hold-to-repeat.
module btn_repeat_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 100_000,
   parameter int REPEAT_DELAY    = 5_000_000,
   parameter int REPEAT_PERIOD   = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button_in,
   input  logic enable,
   input  logic repeat_en,
   output logic pulse_o,
   output logic repeat_o,
   output logic level_o,
   output logic release_o
);

   localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int MAX_N  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
   localparam int CW     = $clog2(MAX_N + 1);

   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [2:0] {
      IDLE,
      PRESS_DB,
      HOLD_DELAY,
      HOLD_REPEAT,
      RELEASE_DB
   } state_t;

   logic [1:0]             rst_pipe;
   logic                   rst_int_n;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   btn_s;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          pulse_nxt, repeat_nxt, level_nxt, release_nxt;

   // Reset asserts asynchronously but is released only on a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_pipe <= '0;
      end else begin
         rst_pipe <= {rst_pipe[0], 1'b1};
      end
   end

   assign rst_int_n = rst_pipe[1];

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], button_in};
      end
   end

   assign btn_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state     <= IDLE;
         cnt       <= '0;
         pulse_o   <= 1'b0;
         repeat_o  <= 1'b0;
         level_o   <= 1'b0;
         release_o <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         pulse_o   <= pulse_nxt;
         repeat_o  <= repeat_nxt;
         level_o   <= level_nxt;
         release_o <= release_nxt;
      end
   end

   // The shared counter restarts at zero whenever the state changes.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pulse_nxt   = 1'b0;
      repeat_nxt  = 1'b0;
      release_nxt = 1'b0;

      if (!enable) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               cnt_nxt = '0;
               if (btn_s) begin
                  state_nxt = PRESS_DB;
               end
            end
            PRESS_DB: begin
               if (!btn_s) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end else if (cnt == DB_LAST) begin
                  state_nxt = HOLD_DELAY;
                  cnt_nxt   = '0;
                  pulse_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end
            HOLD_DELAY: begin
               // Without repeat permission the counter parks at its terminal value.
               if (!btn_s) begin
                  state_nxt = RELEASE_DB;
                  cnt_nxt   = '0;
               end else if (cnt == RD_LAST) begin
                  if (repeat_en) begin
                     state_nxt  = HOLD_REPEAT;
                     cnt_nxt    = '0;
                     pulse_nxt  = 1'b1;
                     repeat_nxt = 1'b1;
                  end
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end
            HOLD_REPEAT: begin
               if (!btn_s) begin
                  state_nxt = RELEASE_DB;
                  cnt_nxt   = '0;
               end else if (!repeat_en) begin
                  state_nxt = HOLD_DELAY;
                  cnt_nxt   = '0;
               end else if (cnt == RP_LAST) begin
                  cnt_nxt    = '0;
                  pulse_nxt  = 1'b1;
                  repeat_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end
            RELEASE_DB: begin
               if (btn_s) begin
                  state_nxt = HOLD_DELAY;
                  cnt_nxt   = '0;
               end else if (cnt == DB_LAST) begin
                  state_nxt   = IDLE;
                  cnt_nxt     = '0;
                  release_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end

      level_nxt = (state_nxt == HOLD_DELAY) || (state_nxt == HOLD_REPEAT) ||
                  (state_nxt == RELEASE_DB);
   end

endmodule

// File: tb/tb_btn_repeat_conditioner.sv
// Directed bench for btn_repeat_conditioner using small debounce/repeat constants
// so press, repeat, release, reset and enable timing can be checked edge by edge.
module tb_btn_repeat_conditioner;

   logic clk;
   logic rst_n;
   logic button_in;
   logic enable;
   logic repeat_en;
   logic pulse_o;
   logic repeat_o;
   logic level_o;
   logic release_o;

   int checks;
   int failures;

   btn_repeat_conditioner #(
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (10),
      .REPEAT_PERIOD  (3)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .button_in(button_in),
      .enable   (enable),
      .repeat_en(repeat_en),
      .pulse_o  (pulse_o),
      .repeat_o (repeat_o),
      .level_o  (level_o),
      .release_o(release_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs change on the falling edge so the next rising edge samples them cleanly.
   task automatic applyStimulus(input logic btn, input int cycles);
      button_in = btn;
      repeat (cycles) @(negedge clk);
   endtask

   // Expected vector order: {pulse_o, repeat_o, level_o, release_o}.
   task automatic checkOutput(input string tag, input logic [3:0] expected);
      logic [3:0] observed;
      observed = {pulse_o, repeat_o, level_o, release_o};
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      button_in = 1'b0;
      enable    = 1'b1;
      repeat_en = 1'b0;

      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(~button_in, 1);
         checkOutput($sformatf("in_reset c%0d", i), 4'b0000);
      end

      rst_n = 1'b1;
      applyStimulus(1'b0, 6);
      checkOutput("after_reset", 4'b0000);

      $display("[TB] press and release, repeat disabled");
      for (int e = 1; e <= 20; e++) begin
         applyStimulus(1'b1, 1);
         checkOutput($sformatf("norep_hold e%0d", e), {e == 7, 1'b0, e >= 7, 1'b0});
      end
      for (int e = 21; e <= 30; e++) begin
         applyStimulus(1'b0, 1);
         checkOutput($sformatf("norep_release e%0d", e), {1'b0, 1'b0, e < 27, e == 27});
      end

      $display("[TB] glitch rejection");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1);
         checkOutput($sformatf("glitch_high c%0d", i), 4'b0000);
      end
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1);
         checkOutput($sformatf("glitch_gap c%0d", i), 4'b0000);
         applyStimulus(1'b1, 1);
         checkOutput($sformatf("glitch_burst c%0d", i), 4'b0000);
      end
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1);
         checkOutput($sformatf("glitch_tail c%0d", i), 4'b0000);
      end

      $display("[TB] hold to repeat");
      repeat_en = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         logic rep;
         rep = (e >= 17) && (((e - 17) % 3) == 0);
         applyStimulus(1'b1, 1);
         checkOutput($sformatf("repeat_hold e%0d", e), {(e == 7) || rep, rep, e >= 7, 1'b0});
      end

      $display("[TB] repeat_en drop and release bounce");
      repeat_en = 1'b0;
      for (int e = 41; e <= 43; e++) begin
         applyStimulus(1'b1, 1);
         checkOutput($sformatf("repeat_drop e%0d", e), 4'b0010);
      end
      for (int f = 1; f <= 14; f++) begin
         applyStimulus((f == 3) || (f == 4), 1);
         checkOutput($sformatf("release_bounce f%0d", f), {1'b0, 1'b0, f < 11, f == 11});
      end

      $display("[TB] reset during hold");
      repeat_en = 1'b1;
      for (int e = 1; e <= 14; e++) begin
         applyStimulus(1'b1, 1);
         checkOutput($sformatf("pre_reset e%0d", e), {e == 7, 1'b0, e >= 7, 1'b0});
      end
      rst_n = 1'b0;
      #1;
      checkOutput("reset_immediate", 4'b0000);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1);
         checkOutput($sformatf("reset_held c%0d", i), 4'b0000);
      end
      rst_n = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         applyStimulus(1'b1, 1);
         if (e <= 4) begin
            checkOutput($sformatf("post_reset e%0d", e), 4'b0000);
         end else if (e == 12) begin
            checkOutput("post_reset_hold", 4'b0010);
         end
      end

      $display("[TB] enable drop with button held");
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1);
         checkOutput($sformatf("disabled c%0d", i), 4'b0000);
      end
      enable = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         applyStimulus(1'b1, 1);
         checkOutput($sformatf("reenable e%0d", e), {e == 5, 1'b0, e >= 5, 1'b0});
      end
      for (int f = 1; f <= 10; f++) begin
         applyStimulus(1'b0, 1);
         checkOutput($sformatf("final_release f%0d", f), {1'b0, 1'b0, f < 7, f == 7});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
